branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

In-order tracking queue for in-flight conditional branches, sitting directly downstream of the tournament branch predictor. Each prediction is recorded with its PC, predicted direction and the 12-bit path-history snapshot taken at prediction time. Resolutions from execute may arrive in any order; a mispredict squashes all younger entries and emits a repaired path history. Entries retire in program order as update packets (pc, taken) that drive the predictor's table training.

## Interface
- DEPTH, 8, entries; power of two, ≥2
- PC_W, 10, branch PC width
- HIST_W, 12, path-history width
- TAG_W, $clog2(DEPTH), slot tag width (derived)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- alloc_valid  in  1  predictor has a new prediction
- alloc_ready  out  1  slot available
- alloc_pc  in  PC_W  branch PC
- alloc_pred  in  1  predicted direction
- alloc_hist  in  HIST_W  path history used for this prediction
- alloc_tag  out  TAG_W  slot assigned, valid with alloc handshake
- res_valid  in  1  execute resolved a branch
- res_tag  in  TAG_W  resolved slot
- res_taken  in  1  actual direction
- upd_valid  out  1  head entry ready to retire
- upd_ready  in  1  predictor accepts update
- upd_pc / upd_taken / upd_hist / upd_mispredict  out  PC_W/1/HIST_W/1  retire packet
- flush_valid  out  1  one-cycle mispredict pulse
- flush_hist  out  HIST_W  repaired history
- count  out  TAG_W+1  occupied entries

## Operation
- Per-entry state: EMPTY → PENDING (alloc) → RESOLVED (res) → EMPTY (retire or squash).
- head/tail pointers carry an extra wrap bit; full when indices equal and wrap bits differ; empty when identical.
- alloc_tag = tail index; alloc_ready = !full && !flush_valid.
- Resolution accepted only if res_tag is PENDING; otherwise ignored. Stores taken, mispredict = (res_taken != pred).
- On accepted mispredict: every entry younger than res_tag → EMPTY, tail = res_tag+1 (wrap bit adjusted), flush_hist = {res_taken, hist[HIST_W-1:1]} (same right-shift, MSB-insert as the predictor's path history).
- Later mispredict on an older entry squashes further; younger squashed tags are ignored if resolved.
- Retire: upd_valid = head state RESOLVED; packet is head fields; pop when upd_valid && upd_ready.

## Timing
- Reset: head = tail = 0, all EMPTY, alloc_ready=1, upd_valid=0, flush_valid=0, flush_hist=0, count=0, outputs zero.
- Alloc accepted on edge with valid&&ready; entry PENDING next cycle.
- Res at edge N → RESOLVED at N+1; upd_valid for head at N+1 (combinational from state); flush_valid high exactly cycle N+1.
- alloc_ready low during the flush_valid cycle.
- Alloc and mispredict resolution same edge: new entry is younger, squashed; tail = res_tag+1 wins.
- Alloc and retire same edge: both performed; count unchanged.
- Full and retiring: alloc_ready stays 0 that cycle (no combinational bypass).
- upd_valid held with stable packet until upd_ready.
- Reset mid-operation clears everything on that edge; no flush pulse.

## Configuration
- BRQ_STATS_EN defined: adds outputs stat_retired and stat_mispred (16-bit, saturating at 16'hFFFF), incremented per retired entry / per retired entry with upd_mispredict; cleared on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package bp_pkg: entry-state enum (EMPTY/PENDING/RESOLVED), entry struct (pc, pred, taken, hist), PC_W/HIST_W defaults, history-repair function.
- One sub-module: brq_entry (single slot register + state machine), instantiated DEPTH times; pointer/squash logic in top.

## Test plan
- Reset, alloc pc=0x005 pred=1 hist=0x000, res tag0 taken=1 → upd_valid next cycle, upd_pc=0x005, upd_taken=1, upd_mispredict=0, no flush.
- Alloc 8 entries without resolving → alloc_ready=0, count=8; 9th alloc held; retire one → alloc_ready=1.
- Alloc tags 0–3, resolve 2 then 0 then 1 then 3 → retires strictly 0,1,2,3.
- Alloc tags 0–4, res tag1 pred=0 taken=1 hist=0x002 → flush_valid one cycle, flush_hist=0x801, count=2, tags 2–4 later res ignored, next alloc gets tag2.
- Mispredict res and alloc same edge → new entry squashed, tail = res_tag+1.
- Reset asserted with 5 entries pending → count=0, upd_valid=0 next cycle; with BRQ_STATS_EN 20 retires (1 mispred) → stat_retired=20, stat_mispred=1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: entry state, queue entry record and the
// path-history repair used when a mispredict rewinds speculative history.
package bp_pkg;

    localparam int BP_PC_W   = 10;
    localparam int BP_HIST_W = 12;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [BP_PC_W-1:0]   pc;
        logic                 pred;
        logic                 taken;
        logic [BP_HIST_W-1:0] hist;
    } brq_entry_t;

    // Same right-shift / MSB-insert update the predictor applies to its path history.
    function automatic logic [BP_HIST_W-1:0] repair_hist(input logic [BP_HIST_W-1:0] hist,
                                                         input logic                 taken);
        return {taken, hist[BP_HIST_W-1:1]};
    endfunction

endpackage

// File: rtl/brq_entry.sv
// One branch-resolve-queue slot: EMPTY -> PENDING -> RESOLVED -> EMPTY,
// holding the prediction record and the resolved direction.
module brq_entry
    import bp_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_we,
    input  logic [BP_PC_W-1:0]   alloc_pc,
    input  logic                 alloc_pred,
    input  logic [BP_HIST_W-1:0] alloc_hist,
    input  logic                 res_we,
    input  logic                 res_taken,
    input  logic                 squash,
    input  logic                 retire,
    output entry_state_e         state,
    output brq_entry_t           ent
);

    entry_state_e state_q;
    brq_entry_t   ent_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else if (squash || retire) begin
            state_q <= EMPTY;
        end else if (res_we && (state_q == PENDING)) begin
            state_q <= RESOLVED;
        end else if (alloc_we && (state_q == EMPTY)) begin
            state_q <= PENDING;
        end
    end

    // Payload carries no reset; it is only observed while the slot is occupied.
    always_ff @(posedge clock) begin
        if (alloc_we) begin
            ent_q.pc   <= alloc_pc;
            ent_q.pred <= alloc_pred;
            ent_q.hist <= alloc_hist;
        end
        if (res_we) begin
            ent_q.taken <= res_taken;
        end
    end

    assign state = state_q;
    assign ent   = ent_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight conditional branches between predictor and execute.
// Optional BRQ_STATS_EN adds saturating retire / mispredict counters.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PC_W   = BP_PC_W,
    parameter int HIST_W = BP_HIST_W,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic              alloc_pred,
    input  logic [HIST_W-1:0] alloc_hist,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              res_valid,
    input  logic [TAG_W-1:0]  res_tag,
    input  logic              res_taken,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [PC_W-1:0]   upd_pc,
    output logic              upd_taken,
    output logic [HIST_W-1:0] upd_hist,
    output logic              upd_mispredict,
    output logic              flush_valid,
    output logic [HIST_W-1:0] flush_hist,
    output logic [TAG_W:0]    count
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]       stat_retired,
    output logic [15:0]       stat_mispred
`endif
);

    entry_state_e      state [DEPTH];
    brq_entry_t        ent   [DEPTH];

    logic [TAG_W:0]    head_q, tail_q;
    logic [TAG_W-1:0]  head_idx, tail_idx, res_rel;
    logic              full, alloc_fire, res_acc, res_mis, pop;
    logic [DEPTH-1:0]  alloc_we, res_we, squash, retire;
    logic              flush_valid_q;
    logic [HIST_W-1:0] flush_hist_q;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign count    = tail_q - head_q;

    assign alloc_ready = !full && !flush_valid_q;
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign res_acc = res_valid && (state[res_tag] == PENDING);
    assign res_mis = res_acc && (res_taken != ent[res_tag].pred);
    // Age of the resolved slot relative to the oldest entry; anything older-than-this is kept.
    assign res_rel = res_tag - head_idx;

    assign upd_valid      = (state[head_idx] == RESOLVED);
    assign pop            = upd_valid && upd_ready;
    assign upd_pc         = upd_valid ? ent[head_idx].pc   : '0;
    assign upd_taken      = upd_valid ? ent[head_idx].taken : 1'b0;
    assign upd_hist       = upd_valid ? ent[head_idx].hist : '0;
    assign upd_mispredict = upd_valid && (ent[head_idx].taken != ent[head_idx].pred);

    assign flush_valid = flush_valid_q;
    assign flush_hist  = flush_hist_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam logic [TAG_W-1:0] IDX = TAG_W'(i);
        logic [TAG_W-1:0] rel;

        assign rel = IDX - head_idx;
        // A mispredict on the same edge kills the incoming allocation as well.
        assign alloc_we[i] = alloc_fire && !res_mis && (tail_idx == IDX);
        assign res_we[i]   = res_acc && (res_tag == IDX);
        assign squash[i]   = res_mis && (rel > res_rel);
        assign retire[i]   = pop && (head_idx == IDX);

        brq_entry u_entry (
            .clock      (clock),
            .reset      (reset),
            .alloc_we   (alloc_we[i]),
            .alloc_pc   (alloc_pc),
            .alloc_pred (alloc_pred),
            .alloc_hist (alloc_hist),
            .res_we     (res_we[i]),
            .res_taken  (res_taken),
            .squash     (squash[i]),
            .retire     (retire[i]),
            .state      (state[i]),
            .ent        (ent[i])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            // Rewinding from head keeps the wrap bit consistent with the surviving entries.
            if (res_mis) begin
                tail_q <= head_q + {1'b0, res_rel} + 1'b1;
            end else if (alloc_fire) begin
                tail_q <= tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            flush_valid_q <= 1'b0;
            flush_hist_q  <= '0;
        end else begin
            flush_valid_q <= res_mis;
            if (res_mis) begin
                flush_hist_q <= repair_hist(ent[res_tag].hist, res_taken);
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [15:0] stat_retired_q, stat_mispred_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_retired_q <= '0;
            stat_mispred_q <= '0;
        end else if (pop) begin
            if (stat_retired_q != 16'hFFFF) begin
                stat_retired_q <= stat_retired_q + 16'd1;
            end
            if (upd_mispredict && (stat_mispred_q != 16'hFFFF)) begin
                stat_mispred_q <= stat_mispred_q + 16'd1;
            end
        end
    end

    assign stat_retired = stat_retired_q;
    assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue; stats checks compile in with BRQ_STATS_EN.
module tb_branch_resolve_queue;

    localparam int DEPTH  = 8;
    localparam int PC_W   = 10;
    localparam int HIST_W = 12;
    localparam int TAG_W  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              alloc_valid, alloc_ready, alloc_pred;
    logic [PC_W-1:0]   alloc_pc;
    logic [HIST_W-1:0] alloc_hist;
    logic [TAG_W-1:0]  alloc_tag;
    logic              res_valid, res_taken;
    logic [TAG_W-1:0]  res_tag;
    logic              upd_valid, upd_ready, upd_taken, upd_mispredict;
    logic [PC_W-1:0]   upd_pc;
    logic [HIST_W-1:0] upd_hist;
    logic              flush_valid;
    logic [HIST_W-1:0] flush_hist;
    logic [TAG_W:0]    count;
`ifdef BRQ_STATS_EN
    logic [15:0]       stat_retired, stat_mispred;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W), .TAG_W(TAG_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_pc       (alloc_pc),
        .alloc_pred     (alloc_pred),
        .alloc_hist     (alloc_hist),
        .alloc_tag      (alloc_tag),
        .res_valid      (res_valid),
        .res_tag        (res_tag),
        .res_taken      (res_taken),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_hist       (upd_hist),
        .upd_mispredict (upd_mispredict),
        .flush_valid    (flush_valid),
        .flush_hist     (flush_hist),
        .count          (count)
`ifdef BRQ_STATS_EN
        ,
        .stat_retired   (stat_retired),
        .stat_mispred   (stat_mispred)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_pc    = '0;
        alloc_pred  = 1'b0;
        alloc_hist  = '0;
        res_valid   = 1'b0;
        res_tag     = '0;
        res_taken   = 1'b0;
        upd_ready   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic pred, input logic [HIST_W-1:0] hist);
        alloc_valid = 1'b1;
        alloc_pc    = pc;
        alloc_pred  = pred;
        alloc_hist  = hist;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken);
        res_valid = 1'b1;
        res_tag   = tag;
        res_taken = taken;
        step();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
        n_checks++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flush_valid: got %b expected 0", flush_valid); end
        n_checks++; if (flush_hist !== 12'h000) begin n_fail++; $display("FAIL reset_flush_hist: got %h expected 000", flush_hist); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag); end
        n_checks++; if (upd_pc !== 10'h000) begin n_fail++; $display("FAIL reset_upd_pc: got %h expected 000", upd_pc); end
    endtask

    task automatic test_basic();
        apply_reset();
        push(10'h005, 1'b1, 12'h000);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", count); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pending_upd: got %b expected 0", upd_valid); end
        resolve(3'd0, 1'b1);
        n_checks++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_upd_valid: got %b expected 1", upd_valid); end
        n_checks++; if (upd_pc !== 10'h005) begin n_fail++; $display("FAIL basic_upd_pc: got %h expected 005", upd_pc); end
        n_checks++; if (upd_taken !== 1'b1) begin n_fail++; $display("FAIL basic_upd_taken: got %b expected 1", upd_taken); end
        n_checks++; if (upd_mispredict !== 1'b0) begin n_fail++; $display("FAIL basic_upd_mispredict: got %b expected 0", upd_mispredict); end
        n_checks++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL basic_flush: got %b expected 0", flush_valid); end
        step();
        n_checks++; if (upd_pc !== 10'h005 || upd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got valid %b pc %h expected 1 005", upd_valid, upd_pc); end
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        n_checks++; if (count !== 4'd0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_retire: got count %0d valid %b expected 0 0", count, upd_valid); end
    endtask

    task automatic test_full();
        apply_reset();
        alloc_valid = 1'b1;
        alloc_pred  = 1'b0;
        alloc_hist  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_pc = PC_W'(i);
            step();
        end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", count); end
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", alloc_ready); end
        alloc_pc = 10'h3FF;
        step();
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_held: got %0d expected 8", count); end
        resolve(3'd0, 1'b0);
        n_checks++; if (upd_valid !== 1'b1 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_retire_ready: got valid %b ready %b expected 1 0", upd_valid, alloc_ready); end
        upd_ready = 1'b1;
        step();
        upd_ready   = 1'b0;
        alloc_valid = 1'b0;
        n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_after_retire_count: got %0d expected 7", count); end
        n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL full_after_retire_ready: got ready %b tag %0d expected 1 0", alloc_ready, alloc_tag); end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        for (int i = 0; i < 4; i++) push(PC_W'(16 + i), 1'b1, HIST_W'(i));
        resolve(3'd2, 1'b1);
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_head_pending: got %b expected 0", upd_valid); end
        resolve(3'd0, 1'b1);
        n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 10'h010) begin n_fail++; $display("FAIL ooo_head_ready: got valid %b pc %h expected 1 010", upd_valid, upd_pc); end
        resolve(3'd1, 1'b1);
        resolve(3'd3, 1'b1);
        upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (upd_valid !== 1'b1 || upd_pc !== PC_W'(16 + k) || upd_hist !== HIST_W'(k)) begin
                n_fail++;
                $display("FAIL ooo_retire_order: got valid %b pc %h hist %h expected 1 %h %h", upd_valid, upd_pc, upd_hist, 16 + k, k);
            end
            step();
        end
        upd_ready = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ooo_drained: got %0d expected 0", count); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        for (int i = 0; i < 5; i++) push(PC_W'(32 + i), 1'b0, (i == 1) ? 12'h002 : 12'h000);
        resolve(3'd1, 1'b1);
        n_checks++; if (flush_valid !== 1'b1) begin n_fail++; $display("FAIL mis_flush_valid: got %b expected 1", flush_valid); end
        n_checks++; if (flush_hist !== 12'h801) begin n_fail++; $display("FAIL mis_flush_hist: got %h expected 801", flush_hist); end
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL mis_count: got %0d expected 2", count); end
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL mis_ready_during_flush: got %b expected 0", alloc_ready); end
        step();
        n_checks++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush_one_cycle: got %b expected 0", flush_valid); end
        n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd2) begin n_fail++; $display("FAIL mis_next_tag: got ready %b tag %0d expected 1 2", alloc_ready, alloc_tag); end
        resolve(3'd3, 1'b1);
        resolve(3'd2, 1'b1);
        n_checks++; if (count !== 4'd2 || flush_valid !== 1'b0) begin n_fail++; $display("FAIL mis_squashed_res_ignored: got count %0d flush %b expected 2 0", count, flush_valid); end
        resolve(3'd0, 1'b0);
        n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 10'h020 || upd_mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_head0: got valid %b pc %h mis %b expected 1 020 0", upd_valid, upd_pc, upd_mispredict); end
        upd_ready = 1'b1;
        step();
        n_checks++; if (upd_pc !== 10'h021 || upd_mispredict !== 1'b1 || upd_taken !== 1'b1 || upd_hist !== 12'h002) begin n_fail++; $display("FAIL mis_head1: got pc %h mis %b taken %b hist %h expected 021 1 1 002", upd_pc, upd_mispredict, upd_taken, upd_hist); end
        step();
        upd_ready = 1'b0;
        n_checks++; if (count !== 4'd0 || alloc_tag !== 3'd2) begin n_fail++; $display("FAIL mis_drained: got count %0d tag %0d expected 0 2", count, alloc_tag); end
    endtask

    task automatic test_same_edge_alloc_mispredict();
        apply_reset();
        for (int i = 0; i < 3; i++) push(PC_W'(48 + i), 1'b1, 12'h0F0);
        alloc_valid = 1'b1;
        alloc_pc    = 10'h077;
        alloc_pred  = 1'b1;
        alloc_hist  = 12'h000;
        n_checks++; if (alloc_tag !== 3'd3) begin n_fail++; $display("FAIL same_edge_tag_before: got %0d expected 3", alloc_tag); end
        resolve(3'd0, 1'b0);
        alloc_valid = 1'b0;
        n_checks++; if (flush_valid !== 1'b1 || flush_hist !== 12'h078) begin n_fail++; $display("FAIL same_edge_flush: got valid %b hist %h expected 1 078", flush_valid, flush_hist); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL same_edge_count: got %0d expected 1", count); end
        n_checks++; if (upd_valid !== 1'b1 || upd_mispredict !== 1'b1 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL same_edge_head: got valid %b mis %b taken %b expected 1 1 0", upd_valid, upd_mispredict, upd_taken); end
        step();
        n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd1) begin n_fail++; $display("FAIL same_edge_tail: got ready %b tag %0d expected 1 1", alloc_ready, alloc_tag); end
    endtask

    task automatic test_alloc_retire();
        apply_reset();
        push(10'h040, 1'b1, 12'h000);
        resolve(3'd0, 1'b1);
        alloc_valid = 1'b1;
        alloc_pc    = 10'h041;
        upd_ready   = 1'b1;
        step();
        alloc_valid = 1'b0;
        upd_ready   = 1'b0;
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL alloc_retire_count: got %0d expected 1", count); end
        n_checks++; if (upd_valid !== 1'b0 || alloc_tag !== 3'd2) begin n_fail++; $display("FAIL alloc_retire_state: got valid %b tag %0d expected 0 2", upd_valid, alloc_tag); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) push(PC_W'(80 + i), 1'b1, 12'hABC);
        res_valid = 1'b1;
        res_tag   = 3'd2;
        res_taken = 1'b0;
        reset     = 1'b0;
        step();
        reset     = 1'b1;
        res_valid = 1'b0;
        n_checks++; if (count !== 4'd0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_state: got count %0d valid %b expected 0 0", count, upd_valid); end
        n_checks++; if (flush_valid !== 1'b0 || flush_hist !== 12'h000) begin n_fail++; $display("FAIL reset_mid_flush: got valid %b hist %h expected 0 000", flush_valid, flush_hist); end
        n_checks++; if (alloc_tag !== 3'd0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ptrs: got tag %0d ready %b expected 0 1", alloc_tag, alloc_ready); end
    endtask

`ifdef BRQ_STATS_EN
    task automatic test_stats();
        apply_reset();
        n_checks++; if (stat_retired !== 16'd0 || stat_mispred !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d %0d expected 0 0", stat_retired, stat_mispred); end
        for (int k = 0; k < 20; k++) begin
            push(PC_W'(k), 1'b1, 12'h000);
            resolve(TAG_W'(k % DEPTH), (k == 7) ? 1'b0 : 1'b1);
            upd_ready = 1'b1;
            step();
            upd_ready = 1'b0;
        end
        n_checks++; if (stat_retired !== 16'd20) begin n_fail++; $display("FAIL stats_retired: got %0d expected 20", stat_retired); end
        n_checks++; if (stat_mispred !== 16'd1) begin n_fail++; $display("FAIL stats_mispred: got %0d expected 1", stat_mispred); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_same_edge_alloc_mispredict();
        test_alloc_retire();
        test_reset_mid();
`ifdef BRQ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
